// File: rtl/key_seq_ctrl_if.sv
// key_seq_ctrl_if
//   Groups the key-schedule sequencer's request/status/control signals so the
//   sequencer and its environment connect through a single port.
//
//   Handshake: the requester pulses start for one cycle while the sequencer is
//   idle (busy=0, done=0). While busy=1 further start pulses are dropped. done
//   pulses for one cycle when a run completes. Reset aborts a run silently, with
//   no done pulse. key_req has no back-pressure. While it is high, the key bit
//   must be on the key register's serial input in that same cycle.
//
//   Signals:
//     start     requester -> sequencer  begin a key expansion
//     key_req   sequencer -> requester  key bit wanted this cycle (LOAD)
//     busy      sequencer -> requester  LOAD or ROUND in progress
//     done      sequencer -> requester  one-cycle completion pulse
//     ctrl_k    sequencer -> key reg    phase code
//     fk, ck    sequencer -> key reg    serial FK / CK constant bits, MSB-first
//     round     sequencer -> observers  round index, 0 outside ROUND
//     bit_cnt   sequencer -> observers  bit position in word, 0 = MSB
//     state_dbg sequencer -> observers  encoded FSM state for checkers
interface key_seq_ctrl_if;
    logic       start;
    logic       key_req;
    logic       busy;
    logic       done;
    logic [1:0] ctrl_k;
    logic       fk;
    logic       ck;
    logic [4:0] round;
    logic [4:0] bit_cnt;
    logic [1:0] state_dbg;

    modport master (
        output start,
        input  key_req, busy, done, ctrl_k, fk, ck, round, bit_cnt, state_dbg
    );

    modport slave (
        input  start,
        output key_req, busy, done, ctrl_k, fk, ck, round, bit_cnt, state_dbg
    );
endinterface

// File: rtl/key_seq_ctrl.sv
// key_seq_ctrl
//   Bit-serial sequencer for the SM4 key schedule. After a start request it
//   runs a 32*LOAD_WORDS-cycle load phase. That phase streams the FK constants
//   MSB-first. It then runs NUM_ROUNDS rounds of 32 cycles each. These stream
//   the CK constants MSB-first together with the ctrl_k phase code. A single
//   done pulse closes each run.
//
//   Ports:
//     clk    system clock, posedge
//     rst_n  synchronous active-low reset
//     bus    key_seq_ctrl_if.slave (start in; key_req, busy, done, ctrl_k,
//            fk, ck, round, bit_cnt, state_dbg out)
//
//   Every output is a combinational decode of the registered state and
//   counters.
module key_seq_ctrl #(
    parameter int NUM_ROUNDS = 32,
    parameter int LOAD_WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    key_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAST_WORD  = 2'(LOAD_WORDS - 1);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] round_q, round_d;
    logic [1:0] word_cnt_q, word_cnt_d;

    logic [31:0] fk_word;
    logic [7:0]  ck_idx;
    logic [7:0]  ck_byte;

    always_comb begin
        fk_word = 32'hA3B1BAC6;
        case (word_cnt_q)
            2'd0:    fk_word = 32'hA3B1BAC6;
            2'd1:    fk_word = 32'h56AA3350;
            2'd2:    fk_word = 32'h677D9197;
            default: fk_word = 32'hB27022DC;
        endcase
    end

    // CK byte j of round i is ((4*i + j) * 7) mod 256. {round, j} is exactly
    // 4*i + j, and the 8-bit multiply supplies the mod-256 truncation.
    assign ck_idx  = {1'b0, round_q, bit_cnt_q[4:3]};
    assign ck_byte = ck_idx * 8'd7;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 5'd0;
            round_q    <= 5'd0;
            word_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            round_q    <= round_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        round_d     = round_q;
        word_cnt_d  = word_cnt_q;

        bus.key_req = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.ctrl_k  = 2'b00;
        bus.fk      = 1'b0;
        bus.ck      = 1'b0;
        bus.round   = 5'd0;
        bus.bit_cnt = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    bit_cnt_d  = 5'd0;
                    word_cnt_d = 2'd0;
                    round_d    = 5'd0;
                end
            end

            S_LOAD: begin
                bus.key_req = 1'b1;
                bus.busy    = 1'b1;
                // bit_cnt counts from the MSB, so invert it to index the word.
                bus.fk      = fk_word[~bit_cnt_q];
                bit_cnt_d   = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = S_ROUND;
                        word_cnt_d = 2'd0;
                        round_d    = 5'd0;
                    end else begin
                        word_cnt_d = word_cnt_q + 2'd1;
                    end
                end
            end

            S_ROUND: begin
                bus.busy  = 1'b1;
                bus.round = round_q;
                bus.ck    = ck_byte[~bit_cnt_q[2:0]];
                if (bit_cnt_q <= 5'd12) begin
                    bus.ctrl_k = 2'b01;
                end else if (bit_cnt_q <= 5'd22) begin
                    bus.ctrl_k = 2'b11;
                end else begin
                    bus.ctrl_k = 2'b10;
                end
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = S_DONE;
                        round_d = 5'd0;
                    end else begin
                        round_d = round_q + 5'd1;
                    end
                end
            end

            default: begin
                // DONE lasts one cycle. A start seen here is dropped.
                bus.done   = 1'b1;
                state_d    = S_IDLE;
                bit_cnt_d  = 5'd0;
                round_d    = 5'd0;
                word_cnt_d = 2'd0;
            end
        endcase
    end

    assign bus.state_dbg = state_q;

endmodule

// File: doc/key_seq_ctrl.md
Name: key_seq_ctrl

Overview:
Bit-serial sequencer for the SM4 key schedule. It sits directly upstream of the serial key register and drives its control and constant inputs. For each key expansion it runs a 128-cycle key-load phase, then 32 rounds of 32 cycles each. During load it streams the FK constants, MSB-first. During rounds it generates the CK constants on the fly, MSB-first, together with the per-bit-position ctrl_k phase code. It also provides start/busy/done handshaking and round/bit position outputs for downstream alignment.

Parameters:
NUM_ROUNDS, 32, number of key-expansion rounds; the round counter is 5 bits, so the legal range is 1..32.
LOAD_WORDS, 4, number of 32-bit key words loaded serially; the load phase lasts 32*LOAD_WORDS cycles.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
start  input  1  single-cycle request to begin a key expansion; honoured only in IDLE.
key_req  output  1  high during LOAD; upstream must present the next key bit on the key register's serial input in the same cycle.
busy  output  1  high in LOAD and ROUND.
done  output  1  one-cycle pulse after the last round cycle.
ctrl_k  output  2  phase code to the key register.
fk  output  1  current FK bit during LOAD, else 0.
ck  output  1  current CK bit during ROUND, else 0.
round  output  5  current round index 0..NUM_ROUNDS-1; 0 outside ROUND.
bit_cnt  output  5  bit position within the current 32-bit word, 0 = MSB.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state is IDLE and all counters are 0.
  - Output values: key_req=0, busy=0, done=0, ctrl_k=0, fk=0, ck=0, round=0, bit_cnt=0.
  - Reset mid-operation aborts immediately and does not pulse done.
- States: IDLE, LOAD, ROUND, DONE. State and counters are registered. All outputs are combinational decodes of the registered state and counters.
- IDLE:
  - start=1 moves to LOAD on the next edge, with word_cnt=0 and bit_cnt=0.
  - start=0 stays in IDLE.
- LOAD (32*LOAD_WORDS cycles):
  - ctrl_k=0, key_req=1, busy=1.
  - fk = FK[word_cnt][31-bit_cnt], where FK0=A3B1BAC6, FK1=56AA3350, FK2=677D9197, FK3=B27022DC.
  - bit_cnt increments every cycle and wraps 31->0; word_cnt increments on that wrap.
  - On the last bit of the last word, move to ROUND with round=0 and bit_cnt=0.
- ROUND (NUM_ROUNDS*32 cycles), ctrl_k is decoded from bit_cnt:
  - 0..12 -> 2'b01
  - 13..22 -> 2'b11
  - 23..31 -> 2'b10
- ROUND, ck generation:
  - ck = CK[round][31-bit_cnt].
  - CK byte j of round i (j=0 is the MSB byte) = ((4*i+j)*7) mod 256, computed arithmetically with 8-bit truncation. No ROM.
- ROUND, counters and exit:
  - bit_cnt wraps 31->0 and round increments on the wrap.
  - On round=NUM_ROUNDS-1 with bit_cnt=31, move to DONE.
- DONE (exactly 1 cycle):
  - done=1, busy=0, ctrl_k=0.
  - Always returns to IDLE. start during DONE is ignored.
- start is ignored while busy=1 or in DONE; no queuing.
- Total latency: start sampled at edge E -> LOAD covers E+1..E+128 -> ROUND covers E+129..E+1152 -> done high during cycle E+1153 (default parameters).
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release with start=0 -> all outputs stay 0 and state stays IDLE for 10 cycles.
- start pulse -> key_req=1 and busy=1 for exactly 128 cycles; first 8 fk bits are 1,0,1,0,0,0,1,1 (A3); word 1 fk starts 0,1,0,1,0,1,1,0 (56).
- ROUND round 0 -> ctrl_k is 01 for 13 cycles, then 11 for 10 cycles, then 10 for 9 cycles; ck serial word reads 00070E15.
- ROUND round 1 -> ck word reads 1C232A31; round 31 -> ck word reads 646B7279.
- start re-pulsed during LOAD and during ROUND -> no effect; done still arrives exactly 1153 cycles after the original start; a start in the DONE cycle is ignored, and a start in the following IDLE cycle restarts.
- rst_n=0 at round 10, bit 5 -> next cycle is IDLE with all outputs 0 and no done pulse; a following start performs a full, correct sequence.
